// File: rtl/ve370_mem_pkg.sv
// Shared types and constants for the cache refill controller.
// Holds the refill FSM state enum, the address field layout and the block geometry.
package ve370_mem_pkg;

    localparam int unsigned ADDR_W   = 10;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned TAG_W    = 5;
    localparam int unsigned BEATS    = 4;
    localparam int unsigned BEAT_W   = $clog2(BEATS);

    // Byte-address layout: tag[9:5], set[4], word[3:2], byte[1:0]
    localparam int unsigned TAG_MSB  = 9;
    localparam int unsigned TAG_LSB  = 5;
    localparam int unsigned SET_BIT  = 4;
    localparam int unsigned WORD_MSB = 3;
    localparam int unsigned WORD_LSB = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } refill_state_t;

endpackage

// File: rtl/blk_beat_cnt.sv
// Beat counter shared by the write-back and refill phases.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   i_clear     force the count back to beat 0
//   i_adv       advance one beat (wraps BEATS-1 -> 0)
//   i_offset    start word added to the count to form the word index
//   o_beat      raw beat count
//   o_idx       beat count plus offset, modulo BEATS
//   o_last      current beat is the final one of the phase
module blk_beat_cnt
    import ve370_mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clear,
    input  logic              i_adv,
    input  logic [BEAT_W-1:0] i_offset,
    output logic [BEAT_W-1:0] o_beat,
    output logic [BEAT_W-1:0] o_idx,
    output logic              o_last
);

    logic [BEAT_W-1:0] r_beat;

    // Natural power-of-two wrap returns the count to 0 at each phase end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat <= '0;
        end else if (i_clear) begin
            r_beat <= '0;
        end else if (i_adv) begin
            r_beat <= r_beat + BEAT_W'(1);
        end
    end

    assign o_beat = r_beat;
    assign o_idx  = r_beat + i_offset;
    assign o_last = (r_beat == BEAT_W'(BEATS - 1));

endmodule

// File: rtl/cache_refill_ctrl.sv
// Block transfer sequencer between a 2-way data cache and main memory.
// On a miss: optional 4-word write-back of a dirty victim, then a 4-word refill.
// Optional feature macro: CRITICAL_WORD_FIRST_EN (refill starts at the missed word,
// adds the crit_valid output pulsing with the first fill write).
// Ports:
//   req/miss_addr/victim_dirty/victim_tag  miss request, captured when accepted in IDLE
//   wb_data/wb_word_idx                    victim word read-out from the cache
//   fill_we/fill_word/fill_data            refill write strobe into the cache
//   busy/done                              transaction status, done is a 1-cycle pulse
//   mem_req/mem_we/mem_addr/mem_wdata      memory beat request
//   mem_rdata/mem_ready                    memory beat completion
module cache_refill_ctrl
    import ve370_mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic [ADDR_W-1:0] miss_addr,
    input  logic              victim_dirty,
    input  logic [TAG_W-1:0]  victim_tag,
    input  logic [DATA_W-1:0] wb_data,
    output logic [BEAT_W-1:0] wb_word_idx,
    output logic              fill_we,
    output logic [BEAT_W-1:0] fill_word,
    output logic [DATA_W-1:0] fill_data,
    output logic              busy,
    output logic              done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
`ifdef CRITICAL_WORD_FIRST_EN
    ,
    output logic              crit_valid
`endif
);

    refill_state_t     r_state;
    refill_state_t     w_state_nxt;
    logic [TAG_W-1:0]  r_miss_tag;
    logic [TAG_W-1:0]  r_victim_tag;
    logic              r_set;
    logic              w_accept;
    logic              w_cnt_clr;
    logic              w_cnt_adv;
    logic [BEAT_W-1:0] w_offset;
    logic [BEAT_W-1:0] w_beat;
    logic [BEAT_W-1:0] w_fword;
    logic              w_last;
    logic              w_unused;

    assign w_accept  = (r_state == IDLE) && req;
    assign w_cnt_clr = (r_state == IDLE);

`ifdef CRITICAL_WORD_FIRST_EN
    logic [BEAT_W-1:0] r_crit_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crit_word <= '0;
        end else if (w_accept) begin
            r_crit_word <= miss_addr[WORD_MSB:WORD_LSB];
        end
    end

    assign w_offset = r_crit_word;
    assign w_unused = ^{miss_addr[WORD_LSB-1:0]};
`else
    assign w_offset = '0;
    assign w_unused = ^{miss_addr[WORD_MSB:0]};
`endif

    blk_beat_cnt u_beat_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_cnt_clr),
        .i_adv    (w_cnt_adv),
        .i_offset (w_offset),
        .o_beat   (w_beat),
        .o_idx    (w_fword),
        .o_last   (w_last)
    );

    // State register plus capture of the miss context on the accepting edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_miss_tag   <= '0;
            r_victim_tag <= '0;
            r_set        <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_miss_tag   <= miss_addr[TAG_MSB:TAG_LSB];
                r_victim_tag <= victim_tag;
                r_set        <= miss_addr[SET_BIT];
            end
        end
    end

    // Next-state and beat outputs; everything idles at zero outside WB/FILL/DONE
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_adv   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        wb_word_idx = '0;
        fill_we     = 1'b0;
        fill_word   = '0;
        fill_data   = '0;
`ifdef CRITICAL_WORD_FIRST_EN
        crit_valid  = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (req) begin
                    w_state_nxt = victim_dirty ? WB : FILL;
                end
            end
            WB: begin
                busy        = 1'b1;
                mem_req     = 1'b1;
                mem_we      = 1'b1;
                mem_addr    = {r_victim_tag, r_set, w_beat, 2'b00};
                wb_word_idx = w_beat;
                mem_wdata   = wb_data;
                if (mem_ready) begin
                    w_cnt_adv = 1'b1;
                    if (w_last) begin
                        w_state_nxt = FILL;
                    end
                end
            end
            FILL: begin
                busy     = 1'b1;
                mem_req  = 1'b1;
                mem_addr = {r_miss_tag, r_set, w_fword, 2'b00};
                if (mem_ready) begin
                    w_cnt_adv = 1'b1;
                    fill_we   = 1'b1;
                    fill_word = w_fword;
                    fill_data = mem_rdata;
`ifdef CRITICAL_WORD_FIRST_EN
                    crit_valid = (w_beat == '0);
`endif
                    if (w_last) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Self-checking bench for cache_refill_ctrl: randomized memory handshakes checked
// against a beat-list model of each transaction (write-back beats then refill beats).
module tb_cache_refill_ctrl;
    import ve370_mem_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req = 1'b0;
    logic [ADDR_W-1:0] miss_addr = '0;
    logic              victim_dirty = 1'b0;
    logic [TAG_W-1:0]  victim_tag = '0;
    logic [DATA_W-1:0] wb_data = '0;
    logic [BEAT_W-1:0] wb_word_idx;
    logic              fill_we;
    logic [BEAT_W-1:0] fill_word;
    logic [DATA_W-1:0] fill_data;
    logic              busy;
    logic              done;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              mem_ready = 1'b0;
`ifdef CRITICAL_WORD_FIRST_EN
    logic              crit_valid;
    localparam bit     CWF = 1'b1;
`else
    localparam bit     CWF = 1'b0;
`endif

    int n_pass  = 0;
    int n_total = 0;

    bit pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    typedef struct {
        logic            we;
        logic [ADDR_W-1:0] addr;
        logic [1:0]      idx;
    } beat_t;

    cache_refill_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .miss_addr    (miss_addr),
        .victim_dirty (victim_dirty),
        .victim_tag   (victim_tag),
        .wb_data      (wb_data),
        .wb_word_idx  (wb_word_idx),
        .fill_we      (fill_we),
        .fill_word    (fill_word),
        .fill_data    (fill_data),
        .busy         (busy),
        .done         (done),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready)
`ifdef CRITICAL_WORD_FIRST_EN
        ,
        .crit_valid   (crit_valid)
`endif
    );

    always #5 clk = ~clk;

    // One miss transaction. mode: 0 ready always, 1 fixed stall pattern, 2 random.
    // abort_after >= 0 returns once that many beats have been accepted.
    task automatic do_txn(input logic dirty, input logic [ADDR_W-1:0] addr,
                          input logic [TAG_W-1:0] vtag, input int mode,
                          input logic hold_req, input int abort_after);
        beat_t q[$];
        beat_t b;
        int    cyc = 0;
        int    popped = 0;
        int    pidx = 0;
        int    n_fill = 0;
        int    n_done = 0;
        int    cw;
        logic  rdy;
        logic  first_fill = 1'b1;
        logic  finished = 1'b0;

        cw = CWF ? int'(addr[3:2]) : 0;
        if (dirty) begin
            for (int w = 0; w < 4; w++) begin
                b.we   = 1'b1;
                b.idx  = 2'(w);
                b.addr = 10'(int'(vtag) * 32 + int'(addr[4]) * 16 + w * 4);
                q.push_back(b);
            end
        end
        for (int k = 0; k < 4; k++) begin
            int fw;
            fw     = (cw + k) % 4;
            b.we   = 1'b0;
            b.idx  = 2'(fw);
            b.addr = 10'(int'(addr[9:5]) * 32 + int'(addr[4]) * 16 + fw * 4);
            q.push_back(b);
        end

        @(negedge clk);
        req = 1'b1; miss_addr = addr; victim_dirty = dirty; victim_tag = vtag;
        mem_ready = 1'($urandom);
        #1;
        n_total++;
        if ({busy, done, mem_req} !== 3'b000)
            $display("FAIL pre_accept got=%b exp=000", {busy, done, mem_req});
        else n_pass++;

        while (!finished) begin
            @(negedge clk);
            cyc++;
            req          = hold_req;
            miss_addr    = 10'($urandom);
            victim_tag   = 5'($urandom);
            victim_dirty = 1'($urandom);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = pat[pidx % 7];
                default: rdy = ($urandom_range(0, 3) != 0);
            endcase
            pidx++;
            mem_ready = rdy;
            mem_rdata = $urandom;
            wb_data   = $urandom;
            #1;
            n_fill += int'(fill_we);
            n_done += int'(done);
            if (q.size() != 0) begin
                b = q[0];
                n_total++;
                if ({busy, done, mem_req, mem_we, fill_we} !== {1'b1, 1'b0, 1'b1, b.we, !b.we && rdy})
                    $display("FAIL ctrl cyc=%0d got=%b exp=%b", cyc,
                             {busy, done, mem_req, mem_we, fill_we}, {1'b1, 1'b0, 1'b1, b.we, !b.we && rdy});
                else n_pass++;
                n_total++;
                if (mem_addr !== b.addr)
                    $display("FAIL mem_addr cyc=%0d got=%h exp=%h", cyc, mem_addr, b.addr);
                else n_pass++;
                if (b.we) begin
                    n_total++;
                    if ({wb_word_idx, mem_wdata} !== {b.idx, wb_data})
                        $display("FAIL wb_beat cyc=%0d got=%0d/%h exp=%0d/%h", cyc,
                                 wb_word_idx, mem_wdata, b.idx, wb_data);
                    else n_pass++;
                end else if (rdy) begin
                    n_total++;
                    if ({fill_word, fill_data} !== {b.idx, mem_rdata})
                        $display("FAIL fill_beat cyc=%0d got=%0d/%h exp=%0d/%h", cyc,
                                 fill_word, fill_data, b.idx, mem_rdata);
                    else n_pass++;
                end
`ifdef CRITICAL_WORD_FIRST_EN
                if (!b.we) begin
                    n_total++;
                    if (crit_valid !== (rdy && first_fill))
                        $display("FAIL crit_valid cyc=%0d got=%b exp=%b", cyc, crit_valid, rdy && first_fill);
                    else n_pass++;
                end
`endif
                if (!b.we && rdy) first_fill = 1'b0;
                if (rdy) begin
                    void'(q.pop_front());
                    popped++;
                end
                if (abort_after >= 0 && popped == abort_after) return;
            end else begin
                n_total++;
                if ({busy, done, mem_req, fill_we} !== 4'b1100)
                    $display("FAIL done_cycle cyc=%0d got=%b exp=1100", cyc, {busy, done, mem_req, fill_we});
                else n_pass++;
                finished = 1'b1;
            end
            if (cyc > 200) begin
                n_total++;
                $display("FAIL timeout cyc=%0d got=busy%b exp=done", cyc, busy);
                finished = 1'b1;
            end
        end

        @(negedge clk);
        req = 1'b0; mem_ready = 1'($urandom);
        #1;
        n_done += int'(done);
        n_total++;
        if ({busy, done, mem_req, fill_we} !== 4'b0000)
            $display("FAIL post_idle got=%b exp=0000", {busy, done, mem_req, fill_we});
        else n_pass++;
        n_total++;
        if (n_fill != 4 || n_done != 1)
            $display("FAIL counts got fill=%0d done=%0d exp fill=4 done=1", n_fill, n_done);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({busy, done, mem_req, mem_we, fill_we, mem_addr, wb_word_idx, fill_word} !== '0)
            $display("FAIL reset got=%b exp=0", {busy, done, mem_req, mem_we, fill_we, mem_addr, wb_word_idx, fill_word});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_clean_miss();
        do_txn(1'b0, 10'h2A4, 5'h07, 0, 1'b0, -1);
    endtask

    task automatic test_dirty_miss();
        do_txn(1'b1, 10'h15C, 5'h03, 0, 1'b0, -1);
    endtask

    task automatic test_stall();
        do_txn(1'b1, 10'h3D0, 5'h1E, 1, 1'b0, -1);
    endtask

    task automatic test_req_ignored();
        do_txn(1'b0, 10'h0C8, 5'h12, 0, 1'b1, -1);
        do_txn(1'b1, 10'h1F4, 5'h09, 1, 1'b1, -1);
    endtask

    task automatic test_reset_mid_wb();
        do_txn(1'b1, 10'h1C4, 5'h1A, 0, 1'b0, 2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({busy, done, mem_req, mem_we, fill_we, mem_addr, wb_word_idx, fill_word} !== '0)
            $display("FAIL reset_mid_wb got=%b exp=0", {busy, done, mem_req, mem_we, fill_we, mem_addr, wb_word_idx, fill_word});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            n_total++;
            if ({busy, done, mem_req} !== 3'b000)
                $display("FAIL after_reset i=%0d got=%b exp=000", i, {busy, done, mem_req});
            else n_pass++;
        end
        do_txn(1'b1, 10'h2A4, 5'h11, 0, 1'b0, -1);
    endtask

    task automatic test_random();
        for (int t = 0; t < 16; t++) begin
            do_txn(1'($urandom), 10'($urandom), 5'($urandom), 2, 1'($urandom), -1);
        end
    endtask

`ifdef CRITICAL_WORD_FIRST_EN
    task automatic test_crit_word();
        do_txn(1'b0, 10'h0B8, 5'h04, 0, 1'b0, -1);
        do_txn(1'b1, 10'h0B8, 5'h1C, 1, 1'b0, -1);
    endtask
`endif

    initial begin
        test_reset();
        test_clean_miss();
        test_dirty_miss();
        test_stall();
        test_req_ignored();
        test_reset_mid_wb();
`ifdef CRITICAL_WORD_FIRST_EN
        test_crit_word();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
